wb_unit: RTL and testbench

Writeback stage directly upstream of the 32x32 register file. It accepts completed instructions from execute, waits on the data memory for loads, and sign/zero-extends load data. It then drives the register file write port (rd/we/wdata) with a registered, one-cycle write. It also exposes the pending write as a forwarding source and keeps a retired-instruction counter.

---
 rtl/wb_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit -- writeback stage feeding the 32x32 register file write port.
//
// Accepts completed instructions from execute. Non-loads are written to the
// register file one cycle after acceptance. Loads wait for the data memory
// response, are sign/zero-extended according to funct3 and the low address
// bits, and are written one cycle after the response arrives. The pending
// write doubles as a forwarding source. A retired-instruction counter and two
// sticky error flags (misaligned/illegal load, load timeout) are maintained.
//
// Ports:
//   clk            clock, all state changes at posedge
//   reset          synchronous, active-high reset
//   ex_valid       execute presents an instruction
//   ex_ready       unit can accept (IDLE and not in reset)
//   ex_rd          destination register
//   ex_is_load     instruction is a load
//   ex_funct3      load type (LB/LH/LW/LBU/LHU)
//   ex_addr_lo     low two bits of the load byte address
//   ex_result      ALU result for non-loads
//   dmem_rvalid    load data valid this cycle
//   dmem_rdata     raw aligned 32-bit word from data memory
//   rd/we/wdata    registered register file write port
//   fwd_valid      same as we; rd/wdata usable for forwarding
//   err_misalign   sticky: misaligned or illegal-funct3 load seen
//   err_timeout    sticky: load response not received in time
//   retired        count of retired instructions (wraps)
// -----------------------------------------------------------------------------
module wb_unit #(
  parameter int LOAD_TIMEOUT = 16,  // 1..255 cycles in WAIT_LOAD before abort
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [1:0]       ex_addr_lo,
  input  logic [31:0]      ex_result,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic [4:0]       rd,
  output logic             we,
  output logic [31:0]      wdata,
  output logic             fwd_valid,
  output logic             err_misalign,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Last counter value before abort: the load gets LOAD_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      state_q, state_d;

  // Load context captured at acceptance.
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_addr_q;
  logic        ld_discard_q;
  logic [7:0]  tmo_cnt_q;

  // Strobes from the control process to the datapath.
  logic        accept;
  logic        capture;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        set_misalign;
  logic        set_timeout;
  logic        cnt_inc;

  logic        ld_bad;
  logic [31:0] ld_fmt;

  // Ready depends only on registered state and reset, never on ex_valid.
  assign ex_ready  = (state_q == S_IDLE) && !reset;
  assign accept    = ex_valid && ex_ready;
  assign fwd_valid = we;

  // ---------------------------------------------------------------------------
  // Legality of the load being offered by execute.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ld_bad = 1'b0;
    unique case (ex_funct3)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = ex_addr_lo[0];
      F3_LW:         ld_bad = (ex_addr_lo != 2'b00);
      default:       ld_bad = 1'b1;  // 011, 110, 111 are not loads
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data formatting from the captured funct3 / address lane.
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = dmem_rdata[7:0];
    unique case (ld_addr_q)
      2'd0: lane_byte = dmem_rdata[7:0];
      2'd1: lane_byte = dmem_rdata[15:8];
      2'd2: lane_byte = dmem_rdata[23:16];
      2'd3: lane_byte = dmem_rdata[31:24];
      default: lane_byte = dmem_rdata[7:0];
    endcase
    lane_half = ld_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    ld_fmt = dmem_rdata;
    unique case (ld_funct3_q)
      F3_LB:   ld_fmt = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  ld_fmt = {24'h000000, lane_byte};
      F3_LH:   ld_fmt = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  ld_fmt = {16'h0000, lane_half};
      default: ld_fmt = dmem_rdata;  // LW; discarded loads never reach here
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state / strobe logic.
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    commit       = 1'b0;
    commit_rd    = ld_rd_q;
    commit_data  = ld_fmt;
    set_misalign = 1'b0;
    set_timeout  = 1'b0;
    cnt_inc      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Stray dmem_rvalid in IDLE is deliberately ignored.
        if (accept) begin
          if (ex_is_load) begin
            capture = 1'b1;
            state_d = S_WAIT_LOAD;
          end else begin
            commit      = 1'b1;
            commit_rd   = ex_rd;
            commit_data = ex_result;
          end
        end
      end

      S_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          // The response is consumed even for a discarded load so the
          // memory side stays in step.
          state_d = S_IDLE;
          if (ld_discard_q) set_misalign = 1'b1;
          else              commit       = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: load context, write port, counters, sticky errors.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd_q      <= '0;
      ld_funct3_q  <= '0;
      ld_addr_q    <= '0;
      ld_discard_q <= 1'b0;
      tmo_cnt_q    <= '0;
      rd           <= '0;
      we           <= 1'b0;
      wdata        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      retired      <= '0;
    end else begin
      // we is a single-cycle pulse per completion.
      we <= 1'b0;

      if (capture) begin
        ld_rd_q      <= ex_rd;
        ld_funct3_q  <= ex_funct3;
        ld_addr_q    <= ex_addr_lo;
        ld_discard_q <= ld_bad;
        tmo_cnt_q    <= '0;
      end else if (cnt_inc) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end

      if (commit) begin
        // x0 is never written, but the result still retires and the
        // address/data registers still update.
        rd      <= commit_rd;
        wdata   <= commit_data;
        we      <= (commit_rd != 5'd0);
        retired <= retired + CNT_W'(1);
      end

      if (set_misalign) err_misalign <= 1'b1;
      if (set_timeout)  err_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_unit -- self-checking bench for wb_unit.
// Expected values come from constants and from a behavioural model of the
// load-formatting and retirement rules kept in this file.
// -----------------------------------------------------------------------------
module tb_wb_unit;

  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] wdata;
  logic        fwd_valid;
  logic        err_misalign;
  logic        err_timeout;
  logic [31:0] retired;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_retired;

  always #5 clk = ~clk;

  wb_unit #(.LOAD_TIMEOUT(LT), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_funct3    (ex_funct3),
    .ex_addr_lo   (ex_addr_lo),
    .ex_result    (ex_result),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .rd           (rd),
    .we           (we),
    .wdata        (wdata),
    .fwd_valid    (fwd_valid),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .retired      (retired)
  );

  // Reference load formatting, from byte/half arithmetic on the word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [1:0] alo,
                                           input logic [31:0] w);
    int unsigned b, h, a;
    a = int'(alo);
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128)   ? b - 256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic is_ld,
                       input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] res);
    ex_valid   = 1'b1;
    ex_rd      = r;
    ex_is_load = is_ld;
    ex_funct3  = f3;
    ex_addr_lo = alo;
    ex_result  = res;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; dmem_rvalid = 1'b0;
    ex_rd = '0; ex_funct3 = '0; ex_addr_lo = '0; ex_result = '0; dmem_rdata = '0;
    repeat (3) tick();
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset got=%0b want=0", ex_ready); end
    reset = 1'b0;
    #1;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", ex_ready); end
    total++; if (we !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b/%0b want=0", we, fwd_valid); end
    total++; if (rd !== 5'd0 || wdata !== 32'd0) begin bad++; $display("FAIL rst_rd_wdata got=%0d/%h want=0/0", rd, wdata); end
    total++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b%0b want=00", err_misalign, err_timeout); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL rst_retired got=%0d want=0", retired); end
    exp_retired = 0;
  endtask

  task automatic test_back_to_back();
    issue(5'd5, 1'b0, 3'b000, 2'd0, 32'h0000_1234);
    total++; if (we !== 1'b1 || rd !== 5'd5 || wdata !== 32'h0000_1234) begin bad++; $display("FAIL b2b_first got=%0b/%0d/%h want=1/5/00001234", we, rd, wdata); end
    issue(5'd6, 1'b0, 3'b000, 2'd0, 32'hFFFF_0000);
    total++; if (we !== 1'b1 || rd !== 5'd6 || wdata !== 32'hFFFF_0000) begin bad++; $display("FAIL b2b_second got=%0b/%0d/%h want=1/6/ffff0000", we, rd, wdata); end
    exp_retired += 2;
    tick();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL b2b_we_drop got=%0b want=0", we); end
    total++; if (retired !== exp_retired) begin bad++; $display("FAIL b2b_retired got=%0d want=%0d", retired, exp_retired); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  alos [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      issue(5'(10 + i), 1'b1, f3s[i], alos[i], 32'h0);
      respond(32'h80FF_7F01);
      exp_retired++;
      total++; if (we !== 1'b1 || rd !== 5'(10 + i) || wdata !== exps[i]) begin bad++; $display("FAIL fmt_%0d got=%0b/%0d/%h want=1/%0d/%h", i, we, rd, wdata, 10 + i, exps[i]); end
    end
    total++; if (retired !== exp_retired) begin bad++; $display("FAIL fmt_retired got=%0d want=%0d", retired, exp_retired); end
  endtask

  task automatic test_load_wait();
    issue(5'd7, 1'b1, 3'b010, 2'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      total++; if (ex_ready !== 1'b0 || we !== 1'b0) begin bad++; $display("FAIL wait_busy_%0d got=%0b/%0b want=0/0", k, ex_ready, we); end
      tick();
    end
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL wait_busy_2 got=%0b want=0", ex_ready); end
    respond(32'hCAFE_F00D);
    exp_retired++;
    total++; if (we !== 1'b1 || rd !== 5'd7 || wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL wait_write got=%0b/%0d/%h want=1/7/cafef00d", we, rd, wdata); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL wait_ready got=%0b want=1", ex_ready); end
    tick();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL wait_pulse got=%0b want=0", we); end
  endtask

  task automatic test_random();
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [4:0]  r;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] d;
    logic [31:0] expv;
    int          gap;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        tick();
        dmem_rvalid = 1'b0;
        total++; if (we !== 1'b0 || ex_ready !== 1'b1) begin bad++; $display("FAIL rnd_stray_%0d got=%0b/%0b want=0/1", i, we, ex_ready); end
      end
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        issue(r, 1'b0, 3'b000, 2'd0, d);
        expv = d;
      end else begin
        f3  = legal_f3[$urandom_range(0, 4)];
        alo = 2'($urandom_range(0, 3));
        if (f3 == 3'b001 || f3 == 3'b101) alo[0] = 1'b0;
        if (f3 == 3'b010) alo = 2'd0;
        issue(r, 1'b1, f3, alo, 32'h0);
        gap = $urandom_range(0, 5);
        for (int k = 0; k < gap; k++) begin
          total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL rnd_busy_%0d got=%0b want=0", i, ex_ready); end
          tick();
        end
        respond(d);
        expv = ref_load(f3, alo, d);
      end
      exp_retired++;
      total++; if (we !== (r != 5'd0) || rd !== r || wdata !== expv) begin bad++; $display("FAIL rnd_%0d got=%0b/%0d/%h want=%0b/%0d/%h", i, we, rd, wdata, r != 5'd0, r, expv); end
      total++; if (retired !== exp_retired) begin bad++; $display("FAIL rnd_retired_%0d got=%0d want=%0d", i, retired, exp_retired); end
    end
  endtask

  task automatic test_misalign();
    issue(5'd9, 1'b1, 3'b010, 2'd2, 32'h0);
    total++; if (err_misalign !== 1'b0) begin bad++; $display("FAIL mis_early got=%0b want=0", err_misalign); end
    tick();
    respond(32'h1111_2222);
    total++; if (we !== 1'b0 || err_misalign !== 1'b1) begin bad++; $display("FAIL mis_lw got=%0b/%0b want=0/1", we, err_misalign); end
    total++; if (ex_ready !== 1'b1 || retired !== exp_retired) begin bad++; $display("FAIL mis_lw_state got=%0b/%0d want=1/%0d", ex_ready, retired, exp_retired); end
    issue(5'd9, 1'b1, 3'b011, 2'd0, 32'h0);
    respond(32'h3333_4444);
    total++; if (we !== 1'b0 || err_misalign !== 1'b1) begin bad++; $display("FAIL mis_f3 got=%0b/%0b want=0/1", we, err_misalign); end
    total++; if (ex_ready !== 1'b1 || retired !== exp_retired) begin bad++; $display("FAIL mis_f3_state got=%0b/%0d want=1/%0d", ex_ready, retired, exp_retired); end
  endtask

  task automatic test_timeout();
    logic saw_we;
    saw_we = 1'b0;
    issue(5'd12, 1'b1, 3'b010, 2'd0, 32'h0);
    for (int k = 0; k < LT - 1; k++) begin
      tick();
      saw_we |= we;
    end
    total++; if (ex_ready !== 1'b0 || err_timeout !== 1'b0 || saw_we !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0b/%0b/%0b want=0/0/0", ex_ready, err_timeout, saw_we); end
    tick();
    total++; if (err_timeout !== 1'b1 || ex_ready !== 1'b1 || we !== 1'b0) begin bad++; $display("FAIL tmo_fire got=%0b/%0b/%0b want=1/1/0", err_timeout, ex_ready, we); end
    respond(32'h5555_AAAA);
    total++; if (we !== 1'b0 || retired !== exp_retired) begin bad++; $display("FAIL tmo_stray got=%0b/%0d want=0/%0d", we, retired, exp_retired); end
  endtask

  task automatic test_x0_reset();
    issue(5'd0, 1'b0, 3'b000, 2'd0, 32'hDEAD_BEEF);
    exp_retired++;
    total++; if (we !== 1'b0 || rd !== 5'd0 || wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL x0_write got=%0b/%0d/%h want=0/0/deadbeef", we, rd, wdata); end
    total++; if (retired !== exp_retired) begin bad++; $display("FAIL x0_retired got=%0d want=%0d", retired, exp_retired); end
    issue(5'd3, 1'b1, 3'b010, 2'd0, 32'h0);
    tick();
    reset = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_is_load = 1'b0; ex_result = 32'h55;
    #1;
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%0b want=0", ex_ready); end
    tick();
    ex_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_retired = 0;
    total++; if (ex_ready !== 1'b1 || we !== 1'b0 || rd !== 5'd0 || wdata !== 32'd0) begin bad++; $display("FAIL rstmid_out got=%0b/%0b/%0d/%h want=1/0/0/0", ex_ready, we, rd, wdata); end
    total++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0 || retired !== 32'd0) begin bad++; $display("FAIL rstmid_clr got=%0b/%0b/%0d want=0/0/0", err_misalign, err_timeout, retired); end
    respond(32'h7777_7777);
    total++; if (we !== 1'b0 || retired !== exp_retired) begin bad++; $display("FAIL rstmid_late got=%0b/%0d want=0/0", we, retired); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_format();
    test_load_wait();
    test_random();
    test_misalign();
    test_timeout();
    test_x0_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
